// File: rtl/emu_reset_sequencer_pkg.sv
// Shared types and constants for the ordered per-stage reset sequencer.
// Holds the FSM state enum, the stage-index width and a small parameter helper.
package emu_reset_seq_pkg;

  localparam int IDX_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    ASSERT,
    RELEASE,
    WAIT_ACK,
    GAP,
    DONE
  } state_e;

  // Zero-length phases still occupy one cycle.
  function automatic int unsigned at_least_one(input int unsigned v);
    return (v == 0) ? 1 : v;
  endfunction

endpackage

// File: rtl/emu_reset_sequencer_if.sv
// Bus between a reset requester / the emulated stages and the reset sequencer.
// Groups the soft-request handshake, per-stage reset/ack lines and status.
interface emu_reset_sequencer_if #(
  parameter int unsigned NUM_STAGES = 4
);
  import emu_reset_seq_pkg::*;

  // req_valid/req_ready: a request transfers on a cycle where both are high.
  // The requester keeps req_valid high until that cycle; the sequencer raises
  // req_ready only while idle and never depends on req_valid to do so.
  logic                  req_valid;
  logic                  req_ready;
  logic [NUM_STAGES-1:0] stage_ack;
  logic [NUM_STAGES-1:0] stage_rst;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [IDX_W-1:0]      err_stage;

  modport master (
    output req_valid, stage_ack,
    input  req_ready, stage_rst, busy, done, err, err_stage
  );

  modport slave (
    input  req_valid, stage_ack,
    output req_ready, stage_rst, busy, done, err, err_stage
  );

endinterface

// File: rtl/emu_reset_sequencer.sv
// Ordered reset sequencer: holds all stages in reset, then releases them one by
// one, waiting (with an optional timeout) for each stage's ack before the next.
module emu_reset_sequencer
  import emu_reset_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES     = 4,
  parameter int unsigned ASSERT_CYCLES  = 16,
  parameter int unsigned STAGE_GAP      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  emu_reset_sequencer_if.slave  bus,
  output state_e                state_dbg
);

  localparam logic [CNT_WIDTH-1:0] ASSERT_LAST  = CNT_WIDTH'(at_least_one(ASSERT_CYCLES) - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_LAST     = CNT_WIDTH'(at_least_one(STAGE_GAP) - 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(at_least_one(TIMEOUT_CYCLES) - 1);
  localparam logic [IDX_W-1:0]     LAST_IDX     = IDX_W'(NUM_STAGES - 1);
  localparam bit                   TIMEOUT_ON   = (TIMEOUT_CYCLES != 0);

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_STAGES-1:0] stage_rst_q, stage_rst_d;
  logic                  err_q, err_d;
  logic [IDX_W-1:0]      err_stage_q, err_stage_d;
  logic                  ack_sel;

  always_comb begin
    ack_sel = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (idx_q == IDX_W'(i)) ack_sel = bus.stage_ack[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    stage_rst_d = stage_rst_q;
    err_d       = err_q;
    err_stage_d = err_stage_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d     = ASSERT;
          cnt_d       = '0;
          err_d       = 1'b0;
          stage_rst_d = '1;
        end
      end

      ASSERT: begin
        stage_rst_d = '1;
        cnt_d       = cnt_q + CNT_WIDTH'(1);
        if (cnt_q == ASSERT_LAST) begin
          state_d = RELEASE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end

      RELEASE: begin
        for (int i = 0; i < NUM_STAGES; i++) begin
          if (idx_q == IDX_W'(i)) stage_rst_d[i] = 1'b0;
        end
        state_d = WAIT_ACK;
        cnt_d   = '0;
      end

      WAIT_ACK: begin
        // Counter frozen when the timeout is disabled so it cannot wrap.
        if (TIMEOUT_ON) cnt_d = cnt_q + CNT_WIDTH'(1);
        if (ack_sel) begin
          state_d = GAP;
          cnt_d   = '0;
        end else if (TIMEOUT_ON && (cnt_q == TIMEOUT_LAST)) begin
          if (!err_q) err_stage_d = idx_q;
          err_d   = 1'b1;
          state_d = GAP;
          cnt_d   = '0;
        end
      end

      GAP: begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = RELEASE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ASSERT;
      cnt_q       <= '0;
      idx_q       <= '0;
      stage_rst_q <= '1;
      err_q       <= 1'b0;
      err_stage_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      stage_rst_q <= stage_rst_d;
      err_q       <= err_d;
      err_stage_q <= err_stage_d;
    end
  end

  assign bus.stage_rst = stage_rst_q;
  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.err       = err_q;
  assign bus.err_stage = err_stage_q;
  assign state_dbg     = state_q;

endmodule
